// File: rtl/lut_sched_pkg.sv
// Shared definitions for the LUT layer scheduler.
// Holds the layer dimensions, the scheduler state encoding, the configuration
// port select codes and the helper that gathers FAN_IN activations into one
// truth-table address.
package lut_sched_pkg;

    localparam int N_NEURONS = 32;
    localparam int IN_ACTS   = 32;
    localparam int BW        = 2;
    localparam int FAN_IN    = 4;
    localparam int ADDR_W    = FAN_IN * BW;
    localparam int IDX_W     = $clog2(IN_ACTS);
    localparam int CFG_W     = FAN_IN * IDX_W;
    localparam int NID_W     = $clog2(N_NEURONS);
    localparam int RAM_AW    = NID_W + ADDR_W;

    localparam logic CFG_SEL_CONN  = 1'b0;
    localparam logic CFG_SEL_TABLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Builds the table address for one neuron: field k of the address is the
    // activation selected by connectivity index k. The activation vector is
    // first padded to the full index range so that any index at or beyond
    // IN_ACTS falls back to activation 0.
    function automatic logic [ADDR_W-1:0] gather_addr(
        input logic [IN_ACTS*BW-1:0] acts,
        input logic [CFG_W-1:0]      conn
    );
        logic [BW*(2**IDX_W)-1:0] padded;
        logic [IDX_W-1:0]         idx;
        logic [ADDR_W-1:0]        addr;
        padded = '0;
        addr   = '0;
        for (int j = 0; j < 2**IDX_W; j++) begin
            if (j < IN_ACTS) begin
                padded[BW*j +: BW] = acts[BW*(j % IN_ACTS) +: BW];
            end else begin
                padded[BW*j +: BW] = acts[BW-1:0];
            end
        end
        for (int k = 0; k < FAN_IN; k++) begin
            idx = conn[IDX_W*k +: IDX_W];
            addr[BW*k +: BW] = padded[BW*idx +: BW];
        end
        return addr;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Shared truth-table storage for all neurons of the layer.
// One entry per (neuron, address) pair, BW bits wide. Contents are not reset.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address {neuron id, table entry}
//   wdata  - write data
//   raddr  - read address {neuron id, table entry}
//   rdata  - read data, valid one cycle after raddr is presented
module lut_table_ram
    import lut_sched_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [BW-1:0]     wdata,
    input  logic [RAM_AW-1:0] raddr,
    output logic [BW-1:0]     rdata
);

    logic [BW-1:0] mem [2**RAM_AW];

    // Single write port plus a registered read; no reset so synthesis is free
    // to map this onto distributed or block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lut_layer_sched.sv
// Time-multiplexed evaluator for one LUT layer: N_NEURONS fan-in-4 neurons are
// evaluated one per cycle through a single shared truth-table RAM.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - input vector handshake, in_data holds the activations
//   out_valid/out_ready  - result handshake, out_data holds the neuron outputs
//   cfg_we/cfg_sel       - config write strobe; select connectivity or table
//   cfg_nid/cfg_entry    - target neuron and table entry
//   cfg_wdata            - connectivity indices or table value
//   cfg_err              - one-cycle pulse after a rejected config write
//   busy                 - high whenever a vector is in flight
module lut_layer_sched
    import lut_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_ACTS*BW-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_NEURONS*BW-1:0] out_data,
    input  logic                    cfg_we,
    input  logic                    cfg_sel,
    input  logic [NID_W-1:0]        cfg_nid,
    input  logic [ADDR_W-1:0]       cfg_entry,
    input  logic [CFG_W-1:0]        cfg_wdata,
    output logic                    cfg_err,
    output logic                    busy
);

    state_t                  state;
    state_t                  state_nx;
    logic [NID_W-1:0]        n_cnt;
    logic [NID_W-1:0]        n_d;
    logic                    rd_vld;
    logic [IN_ACTS*BW-1:0]   in_reg;
    logic [N_NEURONS*BW-1:0] out_reg;
    logic [CFG_W-1:0]        conn [N_NEURONS];
    logic                    in_fire;
    logic                    cfg_ok;
    logic                    conn_we;
    logic                    tbl_we;
    logic                    last_issue;
    logic [RAM_AW-1:0]       rd_addr;
    logic [RAM_AW-1:0]       wr_addr;
    logic [BW-1:0]           rd_data;

    // Holding in_ready low while rst_n is low keeps the port quiet during reset
    // even though the state register already sits in IDLE.
    assign in_ready   = (state == ST_IDLE) && rst_n;
    assign in_fire    = in_valid && in_ready;
    assign cfg_ok     = cfg_we && (state == ST_IDLE) && !in_fire;
    assign conn_we    = cfg_ok && (cfg_sel == CFG_SEL_CONN);
    assign tbl_we     = cfg_ok && (cfg_sel == CFG_SEL_TABLE);
    assign last_issue = (n_cnt == NID_W'(N_NEURONS - 1));
    assign rd_addr    = {n_cnt, gather_addr(in_reg, conn[n_cnt])};
    assign wr_addr    = {cfg_nid, cfg_entry};
    assign out_data   = out_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs. DRAIN exists because the RAM answer for
    // the last issued neuron arrives one cycle after EVAL has finished.
    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (in_fire) begin
                    state_nx = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (last_issue) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture the input vector, step through the neurons, and drop
    // each RAM answer into its slot using the neuron id delayed to match the
    // read latency. n_cnt wraps back to zero after the last issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cnt   <= '0;
            n_d     <= '0;
            rd_vld  <= 1'b0;
            in_reg  <= '0;
            out_reg <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            rd_vld  <= (state == ST_EVAL);
            n_d     <= n_cnt;
            if (in_fire) begin
                in_reg <= in_data;
                n_cnt  <= '0;
            end else if (state == ST_EVAL) begin
                n_cnt <= n_cnt + NID_W'(1);
            end
            if (rd_vld) begin
                out_reg[BW*n_d +: BW] <= rd_data;
            end
        end
    end

    // Connectivity register file, read combinationally during EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                conn[n] <= '0;
            end
        end else if (conn_we) begin
            conn[cfg_nid] <= cfg_wdata;
        end
    end

    lut_table_ram u_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (wr_addr),
        .wdata (cfg_wdata[BW-1:0]),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lut_layer_sched.sv
// Self-checking bench for lut_layer_sched.
// A cycle-count model tracks which phase the block should be in and computes
// every expected result vector from its own copy of connectivity and tables.
module tb_lut_layer_sched;

    localparam int NN = 32;
    localparam int NA = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [4:0]  cfg_nid = '0;
    logic [7:0]  cfg_entry = '0;
    logic [19:0] cfg_wdata = '0;
    logic        cfg_err;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Model state: phase 0 = idle, 1 = running, 2 = result presented.
    int          m_phase = 0;
    int          m_cnt = 0;
    logic        m_err = 1'b0;
    logic [63:0] m_exp = '0;
    int          m_conn [NN][4];
    logic [1:0]  m_tbl [NN][256];

    lut_layer_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_nid   (cfg_nid),
        .cfg_entry (cfg_entry),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected result vector straight from the layer definition.
    function automatic logic [63:0] model_eval(input logic [63:0] v);
        logic [63:0] res;
        int addr;
        int idx;
        int a;
        res = '0;
        for (int n = 0; n < NN; n++) begin
            addr = 0;
            for (int k = 0; k < 4; k++) begin
                idx = m_conn[n][k];
                if (idx < NA) a = int'((v >> (2 * idx)) & 64'd3);
                else          a = int'(v & 64'd3);
                addr = addr + a * (4 ** k);
            end
            res[2*n +: 2] = m_tbl[n][addr];
        end
        return res;
    endfunction

    // Reference model, advanced on every clock edge with the pre-edge inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_err   <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                for (int k = 0; k < 4; k++) begin
                    m_conn[n][k] <= 0;
                end
            end
        end else begin
            m_err <= cfg_we && !(m_phase == 0 && !in_valid);
            if (m_phase == 0) begin
                if (in_valid) begin
                    m_exp   <= model_eval(in_data);
                    m_phase <= 1;
                    m_cnt   <= 0;
                end else if (cfg_we) begin
                    if (cfg_sel) begin
                        m_tbl[cfg_nid][cfg_entry] <= cfg_wdata[1:0];
                    end else begin
                        for (int k = 0; k < 4; k++) begin
                            m_conn[cfg_nid][k] <= int'(cfg_wdata[5*k +: 5]);
                        end
                    end
                end
            end else if (m_phase == 1) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == NN) m_phase <= 2;
            end else if (out_ready) begin
                m_phase <= 0;
            end
        end
    end

    // Compare every cycle, mid-way between rising edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_out_data", out_data, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_cfg_err", cfg_err, 0);
        end else begin
            checkOutput("in_ready", in_ready, m_phase == 0);
            checkOutput("busy", busy, m_phase != 0);
            checkOutput("out_valid", out_valid, m_phase == 2);
            checkOutput("cfg_err", cfg_err, m_err);
            if (m_phase == 2) checkOutput("out_data", out_data, m_exp);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc = cyc + 1;
    endtask

    task automatic cfgWrite(input logic sel, input int nid, input int entry, input logic [19:0] wd);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_nid   = 5'(nid);
        cfg_entry = 8'(entry);
        cfg_wdata = wd;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic startVector(input logic [63:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!out_valid) checkOutput("result_timeout", out_valid, 1);
    endtask

    task automatic applyStimulus(input logic [63:0] v);
        int lat;
        startVector(v);
        waitResult(lat);
        tick();
    endtask

    function automatic logic [63:0] rand_vec();
        return {$urandom, $urandom};
    endfunction

    logic [63:0] basic_vec;
    logic [63:0] saved;
    int lat;
    int t_acc [4];

    initial begin
        // Reset
        repeat (3) tick();
        checkOutput("reset_hold_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_in_ready", in_ready, 1);

        // Fill every table entry and every connectivity word.
        for (int n = 0; n < NN; n++) begin
            for (int e = 0; e < 256; e++) begin
                cfgWrite(1'b1, n, e, 20'($urandom_range(0, 3)));
            end
        end
        for (int n = 0; n < NN; n++) cfgWrite(1'b0, n, 0, 20'($urandom));

        // Random vectors
        for (int i = 0; i < 8; i++) applyStimulus(rand_vec());

        // Basic evaluation of neuron 0
        cfgWrite(1'b0, 0, 0, {5'd3, 5'd2, 5'd1, 5'd0});
        for (int e = 0; e < 256; e++) cfgWrite(1'b1, 0, e, (e == 8'h1B) ? 20'd2 : 20'd0);
        basic_vec = rand_vec();
        basic_vec[7:0] = 8'h1B;
        startVector(basic_vec);
        waitResult(lat);
        checkOutput("basic_latency", 64'(lat), 64'd34);
        checkOutput("basic_n0", out_data[1:0], 2'b10);
        checkOutput("model_n0", m_exp[1:0], 2'b10);
        tick();

        // Backpressure in DONE
        out_ready = 1'b0;
        startVector(rand_vec());
        waitResult(lat);
        saved = out_data;
        in_valid = 1'b1;
        in_data  = rand_vec();
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_data", out_data, saved);
            checkOutput("bp_valid", out_valid, 1);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // Config while busy is rejected and changes nothing
        startVector(basic_vec);
        repeat (3) tick();
        cfgWrite(1'b1, 0, 8'h1B, 20'd1);
        checkOutput("busy_cfg_err", cfg_err, 1);
        tick();
        checkOutput("busy_cfg_err_clear", cfg_err, 0);
        waitResult(lat);
        checkOutput("busy_first_n0", out_data[1:0], 2'b10);
        tick();
        applyStimulus(basic_vec);

        // Handshake wins over a same-cycle config write
        in_valid  = 1'b1;
        in_data   = basic_vec;
        cfg_we    = 1'b1;
        cfg_sel   = 1'b1;
        cfg_nid   = 5'd0;
        cfg_entry = 8'h1B;
        cfg_wdata = 20'd1;
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        checkOutput("race_cfg_err", cfg_err, 1);
        waitResult(lat);
        checkOutput("race_n0", out_data[1:0], 2'b10);
        tick();

        // Boundary: last neuron wired to the last activation
        cfgWrite(1'b0, 31, 0, {5'd31, 5'd31, 5'd31, 5'd31});
        cfgWrite(1'b1, 31, 8'hFF, 20'd3);
        basic_vec[63:62] = 2'b11;
        startVector(basic_vec);
        waitResult(lat);
        checkOutput("bound_n31", out_data[63:62], 2'b11);
        checkOutput("model_n31", m_exp[63:62], 2'b11);
        tick();

        // Back-to-back vectors with in_valid held high
        in_valid = 1'b1;
        for (int v = 0; v < 4; v++) begin
            int n;
            n = 0;
            while (!in_ready && n < 100) begin
                tick();
                n++;
            end
            t_acc[v] = cyc;
            tick();
            in_data = rand_vec();
        end
        in_valid = 1'b0;
        for (int v = 1; v < 4; v++) checkOutput("b2b_interval", 64'(t_acc[v] - t_acc[v-1]), 64'd35);
        waitResult(lat);
        tick();

        // Abort mid-EVAL, then rerun the vector
        startVector(basic_vec);
        repeat (9) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(basic_vec);
        cfgWrite(1'b0, 0, 0, {5'd3, 5'd2, 5'd1, 5'd0});
        cfgWrite(1'b0, 31, 0, {5'd31, 5'd31, 5'd31, 5'd31});
        startVector(basic_vec);
        waitResult(lat);
        checkOutput("abort_n0", out_data[1:0], 2'b10);
        checkOutput("abort_n31", out_data[63:62], 2'b11);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
